dvp_frame_gen: RTL and testbench
================================

# dvp_frame_gen

Synthesizable DVP (OV-style parallel camera) transmitter that produces `p_clock`, `vsync`, `href` and `p_data` from the system clock. Frames carry either an internal test pattern or bytes pulled from an on-chip stream. It drives the camera-capture input pins in loopback and simulation, so the capture path and the downstream classifier can be exercised without a sensor. All outputs use receiver-friendly timing: data and syncs change on the falling edge of `p_clock` and are stable at its rising edge.

## Interface
Parameters:
- `CLK_DIV`, 2: `clk` cycles per `p_clock` half-period; minimum 1.
- `H_ACTIVE`, 1280: bytes per line (`href` high), pixel periods.
- `H_BLANK`, 288: `href`-low pixel periods after each line.
- `V_ACTIVE`, 480: lines per frame.
- `VSYNC_LEN`, 3136: `vsync`-high pixel periods.
- `V_BACK`, 1568: pixel periods from `vsync` fall to first `href`.
- `V_FRONT`, 1568: pixel periods after last line's blank before frame end.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level; sampled every `clk` and latched into `start_pend`.
- `cont` in 1: continuous frames while high; sampled at frame end.
- `pattern_sel` in 1: 0 = column ramp, 1 = line XOR column; sampled at `vsync` rise.
- `s_data` in 8: external byte.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: one-`clk` pulse, byte consumed when `s_valid` is also high.
- `p_clock` out 1: DVP pixel clock, free-running.
- `vsync` out 1: frame sync, active-high.
- `href` out 1: line valid.
- `p_data` out 8: pixel byte.
- `busy` out 1: frame sequence in progress.
- `frame_done` out 1: one-`clk` pulse at end of each frame.
- `underrun` out 1: sticky flag, external byte missing during `href`.

## Operation
- Divider counter `div_cnt` runs 0..CLK_DIV-1. On wrap, `p_clock` toggles.
- `fall_tick` is the `clk` cycle on which `p_clock` goes 1→0. All state, counter and DVP output updates occur only on `fall_tick`.
- FSM states: IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT. Each timed state holds for its parameter count of `fall_tick`s.
  - IDLE → VSYNC when `start_pend`. This clears `start_pend` and `underrun`, and sets `busy`.
  - VSYNC → VBACK.
  - VBACK → LINE.
  - LINE → HBLANK.
  - HBLANK → LINE if `line < V_ACTIVE-1`, else → VFRONT.
  - VFRONT → VSYNC if `cont`, else → IDLE. This transition pulses `frame_done` and, on the IDLE path, clears `busy`.
- Output values per state:
  - `vsync` = 1 only in VSYNC.
  - `href` = 1 only in LINE.
  - `p_data` = 0x00 outside LINE.
- Column counter runs 0..H_ACTIVE-1 and wraps to 0 entering HBLANK. Line counter runs 0..V_ACTIVE-1 and resets at VSYNC.
- Internal pattern, 8-bit:
  - mode 0: `col[7:0]`.
  - mode 1: `line[7:0] ^ col[7:0]`.
- External source (macro only):
  - In LINE, `s_ready` pulses on the `clk` cycle before each `fall_tick`.
  - If `s_valid` is high, `p_data` ← `s_data`. Otherwise `p_data` ← 0x00 and `underrun` is set.
- `start` deasserted mid-frame has no effect: the frame completes. `start` high during a frame re-arms `start_pend`.

## Timing
- Reset values: `p_clock`, `vsync`, `href`, `busy`, `frame_done`, `s_ready` and `underrun` = 0; `p_data` = 0x00; FSM = IDLE; `start_pend` = 0.
- Pixel period is 2·CLK_DIV `clk` cycles.
- Start latency: `vsync` rises on the first `fall_tick` after the `clk` in which `start` was registered. Worst case is 2·CLK_DIV+1 `clk` cycles.
- Frame length: VSYNC_LEN + V_BACK + V_ACTIVE·(H_ACTIVE+H_BLANK) + V_FRONT pixel periods.
- `frame_done` coincides with the `fall_tick` leaving VFRONT.
- Reset asserted mid-frame drops all outputs to reset values immediately. After release, `p_clock` restarts low and `div_cnt` starts at 0.

## Configuration
- `DVP_GEN_EXT_SRC_EN` defined: `pattern_sel` = 1 is reinterpreted as external source. The ramp pattern remains available as mode 0.
- `DVP_GEN_EXT_SRC_EN` undefined:
  - `s_data` and `s_valid` are ignored.
  - `s_ready` is tied to 0 and `underrun` to 0.
  - Only internal patterns are generated.

## Test plan
- Post-reset idle: CLK_DIV=2, no `start`. Required: `p_clock` toggles every 2 `clk`; `vsync`, `href` and `busy` stay 0; `p_data` = 0x00.
- Single frame: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, VSYNC_LEN=2, V_BACK=1, V_FRONT=1, `pattern_sel`=0, `start` pulse, `cont`=0. Required:
  - 2 `vsync` periods, then 3 `href` bursts each of bytes 00,01,02,03.
  - One `frame_done` after 22 pixel periods, then `busy` returns to 0.
  - Every byte is stable at the `p_clock` rising edge.
- XOR pattern: same parameters, `pattern_sel`=1. Required: line 2 bytes are 02,03,00,01.
- Continuous mode: `cont`=1 for 3 frames, then 0. Required: 3 back-to-back frames with no IDLE gap, 3 `frame_done` pulses, and `busy` falls after the third.
- External source (macro on): `s_valid` low on the 3rd byte of line 0. Required: that byte is 0x00, `underrun`=1 sticky until the next `start`, and the other bytes match `s_data`.
- Reset mid-LINE: assert `rst` during `href`=1. Required: all outputs return to reset values within the same cycle, and a new `start` produces a full, correct frame.

Source files
------------

// File: rtl/dvp_frame_gen.sv
// DVP (OV-style) parallel camera transmitter: p_clock, vsync, href and p_data from the system clock.
// Defining DVP_GEN_EXT_SRC_EN turns pattern_sel=1 into an external byte stream (s_data/s_valid).
module dvp_frame_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_ACTIVE  = 1280,
   parameter int unsigned H_BLANK   = 288,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned VSYNC_LEN = 3136,
   parameter int unsigned V_BACK    = 1568,
   parameter int unsigned V_FRONT   = 1568
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cont,
   input  logic       pattern_sel,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       p_clock,
   output logic       vsync,
   output logic       href,
   output logic [7:0] p_data,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CW   = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
   localparam int unsigned LW   = ($clog2(V_ACTIVE) > 8) ? $clog2(V_ACTIVE) : 8;
   localparam int unsigned T1   = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
   localparam int unsigned T2   = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
   localparam int unsigned TMAX = (T1 > T2) ? T1 : T2;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [2:0] {StIdle, StVsync, StVback, StLine, StHblank, StVfront} state_e;

   state_e        state_q;
   logic [DW-1:0] div_cnt_q, div_nxt;
   logic [TW-1:0] tcnt_q;
   logic [CW-1:0] col_q, col_next;
   logic [LW-1:0] line_q, line_next;
   logic          start_pend_q, mode_q;
   logic          wrap, fall_tick, pclk_nxt, last_line, t_last, byte_next;
   logic [7:0]    pix_byte;

   // byte_next: the coming fall_tick presents a LINE byte; col_next/line_next address it.
   always_comb begin
      wrap      = (div_cnt_q == DW'(CLK_DIV - 1));
      fall_tick = wrap & p_clock;
      div_nxt   = wrap ? '0 : div_cnt_q + 1'b1;
      pclk_nxt  = p_clock ^ wrap;
      last_line = (line_q == LW'(V_ACTIVE - 1));
      t_last    = 1'b0;
      col_next  = '0;
      line_next = line_q;
      byte_next = 1'b0;
      case (state_q)
         StVsync:  t_last = (tcnt_q == TW'(VSYNC_LEN - 1));
         StVback: begin
            t_last    = (tcnt_q == TW'(V_BACK - 1));
            byte_next = t_last;
         end
         StLine: begin
            col_next  = col_q + 1'b1;
            byte_next = (col_q != CW'(H_ACTIVE - 1));
         end
         StHblank: begin
            t_last    = (tcnt_q == TW'(H_BLANK - 1));
            line_next = line_q + 1'b1;
            byte_next = t_last & ~last_line;
         end
         StVfront: t_last = (tcnt_q == TW'(V_FRONT - 1));
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q    <= '0;
         p_clock      <= 1'b0;
         state_q      <= StIdle;
         tcnt_q       <= '0;
         col_q        <= '0;
         line_q       <= '0;
         start_pend_q <= 1'b0;
         mode_q       <= 1'b0;
         vsync        <= 1'b0;
         href         <= 1'b0;
         p_data       <= 8'h00;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         div_cnt_q  <= div_nxt;
         p_clock    <= pclk_nxt;
         frame_done <= 1'b0;
         if (start) start_pend_q <= 1'b1;
         if (fall_tick) begin
            case (state_q)
               StIdle: if (start_pend_q) begin
                  state_q      <= StVsync;
                  start_pend_q <= start;
                  busy         <= 1'b1;
                  vsync        <= 1'b1;
                  tcnt_q       <= '0;
                  line_q       <= '0;
                  mode_q       <= pattern_sel;
               end
               StVsync: if (t_last) begin
                  state_q <= StVback;
                  vsync   <= 1'b0;
                  tcnt_q  <= '0;
               end else tcnt_q <= tcnt_q + 1'b1;
               StVback: if (t_last) begin
                  state_q <= StLine;
                  href    <= 1'b1;
                  col_q   <= '0;
                  p_data  <= pix_byte;
               end else tcnt_q <= tcnt_q + 1'b1;
               StLine: if (byte_next) begin
                  col_q  <= col_next;
                  p_data <= pix_byte;
               end else begin
                  state_q <= StHblank;
                  href    <= 1'b0;
                  p_data  <= 8'h00;
                  col_q   <= '0;
                  tcnt_q  <= '0;
               end
               StHblank: if (t_last) begin
                  tcnt_q <= '0;
                  if (last_line) state_q <= StVfront;
                  else begin
                     state_q <= StLine;
                     href    <= 1'b1;
                     line_q  <= line_next;
                     col_q   <= '0;
                     p_data  <= pix_byte;
                  end
               end else tcnt_q <= tcnt_q + 1'b1;
               StVfront: if (t_last) begin
                  tcnt_q     <= '0;
                  frame_done <= 1'b1;
                  if (cont) begin
                     state_q <= StVsync;
                     vsync   <= 1'b1;
                     line_q  <= '0;
                     mode_q  <= pattern_sel;
                  end else begin
                     state_q <= StIdle;
                     busy    <= 1'b0;
                  end
               end else tcnt_q <= tcnt_q + 1'b1;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

`ifdef DVP_GEN_EXT_SRC_EN
   logic pre_fall;

   // Registering on pre_fall puts s_ready high exactly in the cycle ending at the fall edge.
   assign pre_fall = (div_nxt == DW'(CLK_DIV - 1)) & pclk_nxt;
   assign pix_byte = mode_q ? (s_valid ? s_data : 8'h00) : col_next[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ready  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         s_ready <= pre_fall & byte_next & mode_q;
         if (fall_tick & (state_q == StIdle) & start_pend_q) underrun <= 1'b0;
         else if (fall_tick & byte_next & mode_q & ~s_valid) underrun <= 1'b1;
      end
   end
`else
   logic unused_ext;

   assign unused_ext = ^{s_data, s_valid};
   assign pix_byte   = mode_q ? (line_next[7:0] ^ col_next[7:0]) : col_next[7:0];
   assign s_ready    = 1'b0;
   assign underrun   = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Directed bench for dvp_frame_gen on a tiny 4x3 geometry (22 pixel periods per frame).
// Time is tracked as clk edges since reset release; p_clock falls on every 4th edge.
module tb_dvp_frame_gen;

   localparam int FRAME = 22;
`ifdef DVP_GEN_EXT_SRC_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, start, cont, pattern_sel, s_valid;
   logic [7:0] s_data, p_data;
   logic       s_ready, p_clock, vsync, href, busy, frame_done, underrun;
   int         total = 0;
   int         bad = 0;
   int         n = 0;

   always #5 clk = ~clk;

   dvp_frame_gen #(
      .CLK_DIV  (2),
      .H_ACTIVE (4),
      .H_BLANK  (2),
      .V_ACTIVE (3),
      .VSYNC_LEN(2),
      .V_BACK   (1),
      .V_FRONT  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cont       (cont),
      .pattern_sel(pattern_sel),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .p_clock    (p_clock),
      .vsync      (vsync),
      .href       (href),
      .p_data     (p_data),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   task automatic adv(input int target);
      while (n < target) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, n);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, n);
      end
   endtask

   // f0 is the edge of the fall_tick entering VSYNC; checks nf frames plus the final period.
   task automatic run_frames(input int f0, input int nf, input bit mode, input bit ext);
      int         fp, q, l, c;
      bit         last, byte_p;
      logic [7:0] ed;
      for (int p = 0; p <= FRAME * nf; p++) begin
         last   = (p == FRAME * nf);
         fp     = last ? FRAME : p % FRAME;
         q      = fp - 3;
         l      = q / 6;
         c      = q % 6;
         byte_p = !last && fp >= 3 && fp <= 20 && c < 4;
         if (!byte_p) ed = 8'h00;
         else if (ext) ed = (p == 5) ? 8'h00 : 8'(8'hA0 + p);
         else if (mode) ed = 8'(l ^ c);
         else ed = 8'(c);
         adv(f0 + 4 * p - 1);
         chk1("s_ready", s_ready, ext && byte_p);
         adv(f0 + 4 * p);
         chk1("frame_done", frame_done, p > 0 && p % FRAME == 0);
         adv(f0 + 4 * p + 2);
         chk1("p_clock_rise", p_clock, 1'b1);
         chk1("vsync", vsync, !last && fp < 2);
         chk1("href", href, byte_p);
         chk8("p_data", p_data, ed);
         chk1("busy", busy, !last);
         chk1("underrun", underrun, ext && p >= 5);
         if (ext) begin
            s_data  = 8'(8'hA0 + p + 1);
            s_valid = (p + 1 != 5);
         end
         if (p == FRAME * (nf - 1) + 1) cont = 1'b0;
      end
      s_valid = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      cont        = 1'b0;
      pattern_sel = 1'b0;
      s_data      = 8'h00;
      s_valid     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_p_clock", p_clock, 1'b0);
      chk1("rst_vsync", vsync, 1'b0);
      chk1("rst_href", href, 1'b0);
      chk8("rst_p_data", p_data, 8'h00);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_frame_done", frame_done, 1'b0);
      chk1("rst_s_ready", s_ready, 1'b0);
      chk1("rst_underrun", underrun, 1'b0);
      #2 rst = 1'b0;
      n = 0;

      // Idle: p_clock toggles every 2 clk, everything else quiet.
      for (int i = 1; i <= 8; i++) begin
         adv(i);
         chk1("idle_p_clock", p_clock, 1'((i >> 1) & 1));
         chk1("idle_vsync", vsync, 1'b0);
         chk1("idle_href", href, 1'b0);
         chk1("idle_busy", busy, 1'b0);
         chk8("idle_p_data", p_data, 8'h00);
      end

      // Single ramp frame; start registered at edge 9, vsync rises at edge 12.
      start = 1'b1;
      adv(9);
      start = 1'b0;
      run_frames(12, 1, 1'b0, 1'b0);

      // XOR pattern, or the external stream with a missing 3rd byte when enabled.
      adv(104);
      pattern_sel = 1'b1;
      start       = 1'b1;
      adv(105);
      start = 1'b0;
      run_frames(108, 1, 1'b1, EXT);
      adv(200);
      chk1("underrun_sticky", underrun, EXT);
      chk1("idle_after_frame_busy", busy, 1'b0);

      // Three continuous frames; cont drops during the third.
      pattern_sel = 1'b0;
      cont        = 1'b1;
      start       = 1'b1;
      adv(201);
      start = 1'b0;
      run_frames(204, 3, 1'b0, 1'b0);

      // Reset in the middle of line 0.
      adv(472);
      start = 1'b1;
      adv(473);
      start = 1'b0;
      adv(494);
      chk1("pre_rst_href", href, 1'b1);
      rst = 1'b1;
      #1;
      chk1("mid_rst_p_clock", p_clock, 1'b0);
      chk1("mid_rst_vsync", vsync, 1'b0);
      chk1("mid_rst_href", href, 1'b0);
      chk8("mid_rst_p_data", p_data, 8'h00);
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_frame_done", frame_done, 1'b0);
      chk1("mid_rst_s_ready", s_ready, 1'b0);
      chk1("mid_rst_underrun", underrun, 1'b0);
      #2 rst = 1'b0;
      n = 0;
      adv(1);
      chk1("restart_p_clock_e1", p_clock, 1'b0);
      adv(2);
      chk1("restart_p_clock_e2", p_clock, 1'b1);
      adv(4);
      start = 1'b1;
      adv(5);
      start = 1'b0;
      run_frames(8, 1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
